serial_subtractor_moore: RTL and testbench
==========================================

// Module: serial_subtractor_moore
// PURPOSE
//  Bit-serial two's-complement subtractor, the inverse datapath of the serial adder:
//  computes DIFF = A - B one bit per clock, LSB first, with the borrow held in FSM state.
//  Wraps the serial core with a parallel load/unload (valid/ready) interface so it can
//  check or undo adder results in the same bit-serial arithmetic subsystem.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>= 1)
// PORTS
//  clk         in   1      single clock; all state updates on posedge clk
//  reset_n     in   1      synchronous, active-low reset
//  in_valid    in   1      operands a_in/b_in presented
//  in_ready    out  1      block can accept operands (IDLE only)
//  a_in        in   WIDTH  minuend
//  b_in        in   WIDTH  subtrahend
//  out_valid   out  1      diff/borrow_out valid (DONE only)
//  out_ready   in   1      consumer accepts result
//  diff        out  WIDTH  A - B modulo 2^WIDTH
//  borrow_out  out  1      1 when A < B (unsigned)
//  ser_a       out  1      current serial minuend bit (debug/observe)
//  ser_b       out  1      current serial subtrahend bit
//  ser_d       out  1      current serial difference bit
// BEHAVIOUR
//  Reset (reset_n==0 at posedge clk): state=IDLE, bit counter=0, shift regs=0,
//   diff=0, borrow_out=0, out_valid=0; in_ready=0 while reset_n low, else per state.
//  States: IDLE, B0 (shifting, borrow=0), B1 (shifting, borrow=1), DONE.
//  IDLE: in_ready=1. in_valid&&in_ready -> load a_in/b_in into shift regs, cnt=0, go B0.
//   in_valid outside IDLE is ignored (no capture, no error).
//  B0/B1 (one bit per cycle, LSB first): a=sreg_a[0], b=sreg_b[0], br=(state==B1).
//   ser_d = a^b^br; next borrow = (~a&b) | (~(a^b)&br) -> next state B1 if 1 else B0.
//   diff shifts right, ser_d enters at MSB; sreg_a/sreg_b shift right, 0 fill; cnt++.
//   On the cycle cnt==WIDTH-1: borrow_out <= next borrow, go DONE (not B0/B1).
//  DONE: out_valid=1, diff/borrow_out stable. out_ready -> IDLE (out_valid=0 next cycle).
//   Without out_ready, hold indefinitely; diff/borrow_out must not change.
//  Latency: accept at edge T -> out_valid high after edge T+WIDTH. Min word period
//   WIDTH+2 cycles (accept, WIDTH shifts, unload); no overlap between words.
//  ser_a/ser_b/ser_d: 0 in IDLE and DONE; combinational from state and shift regs otherwise.
//  diff is cleared to 0 on load; borrow_out holds previous value until next DONE.
//  Reset mid-shift or in DONE: abort, result discarded, out_valid=0, back to IDLE.
//  WIDTH=1: single shift cycle, B0 -> DONE directly.
//  Arithmetic: unsigned borrow; signed overflow not flagged.
// TESTING
//  1. WIDTH=8, A=0x5A B=0x23, out_ready=1 -> diff=0x37, borrow_out=0, out_valid at T+8.
//  2. A=0x00 B=0x01 -> diff=0xFF, borrow_out=1; FSM in B1 for all 8 shift cycles.
//  3. A=0xFF B=0xFF -> diff=0x00, borrow_out=0; A=0x80 B=0x7F -> 0x01, borrow 0.
//  4. out_ready low 20 cycles in DONE -> out_valid/diff stable; in_valid pulses ignored.
//  5. reset_n low at shift cycle 4 -> next cycle IDLE, out_valid=0, diff=0, in_ready=1
//     after release; then A=0x10 B=0x20 -> diff=0xF0, borrow_out=1.
//  6. Back-to-back: in_valid held, out_ready=1, 100 random pairs -> each result equals
//     (A-B) mod 256 and A<B; period exactly 10 cycles per word.

Source files
------------

// File: rtl/serial_subtractor_moore.sv
// Bit-serial two's-complement subtractor with a parallel valid/ready wrapper.
// Computes diff = a_in - b_in one bit per clock, LSB first. The running borrow
// is encoded in the FSM state (StB0 / StB1) rather than in a separate flop.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset_n    - synchronous active-low reset
//   in_valid   - operands a_in/b_in presented
//   in_ready   - block can accept operands (idle only, low while in reset)
//   a_in       - minuend
//   b_in       - subtrahend
//   out_valid  - diff/borrow_out valid (done only)
//   out_ready  - consumer accepts result
//   diff       - a - b modulo 2^WIDTH
//   borrow_out - 1 when a < b (unsigned)
//   ser_a      - current serial minuend bit (0 when not shifting)
//   ser_b      - current serial subtrahend bit (0 when not shifting)
//   ser_d      - current serial difference bit (0 when not shifting)
module serial_subtractor_moore #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_d
);

  // At least one counter bit so WIDTH=1 still elaborates.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StB0,
    StB1,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sreg_a_q;
  logic [WIDTH-1:0] sreg_b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic shifting;
  logic last_bit;
  logic load;
  logic bit_a;
  logic bit_b;
  logic bit_br;
  logic bit_d;
  logic borrow_nxt;

  // Full-subtractor cell on the current LSBs; borrow-in comes from the state.
  assign shifting   = (state_q == StB0) || (state_q == StB1);
  assign last_bit   = (cnt_q == LastCnt);
  assign load       = (state_q == StIdle) && in_valid;
  assign bit_a      = sreg_a_q[0];
  assign bit_b      = sreg_b_q[0];
  assign bit_br     = (state_q == StB1);
  assign bit_d      = bit_a ^ bit_b ^ bit_br;
  assign borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bit_br);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) state_d = StB0;
      end
      StB0, StB1: begin
        if (last_bit) begin
          state_d = StDone;
        end else begin
          state_d = borrow_nxt ? StB1 : StB0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift registers, bit counter and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sreg_a_q <= '0;
      sreg_b_q <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      sreg_a_q <= a_in;
      sreg_b_q <= b_in;
      diff_q   <= '0;
    end else if (shifting) begin
      cnt_q    <= cnt_q + 1'b1;
      sreg_a_q <= sreg_a_q >> 1;
      sreg_b_q <= sreg_b_q >> 1;
      // Result bits arrive LSB first, so each one enters at the MSB.
      diff_q   <= (diff_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
      if (last_bit) borrow_q <= borrow_nxt;
    end
  end

  // Outputs
  always_comb begin
    in_ready   = reset_n && (state_q == StIdle);
    out_valid  = (state_q == StDone);
    diff       = diff_q;
    borrow_out = borrow_q;
    ser_a      = 1'b0;
    ser_b      = 1'b0;
    ser_d      = 1'b0;
    if (shifting) begin
      ser_a = bit_a;
      ser_b = bit_b;
      ser_d = bit_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_moore.sv
// Directed bench for serial_subtractor_moore (WIDTH=8).
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_serial_subtractor_moore;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ser_a;
  logic         ser_b;
  logic         ser_d;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic prev_borrow;

  serial_subtractor_moore #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_d     (ser_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle; returns the same way.
  // hold > 0 keeps out_ready low that many cycles in DONE with in_valid noise.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                     input logic eb, input int hold, input bit chk_ser);
    chk("idle_ready", in_ready, 1);
    out_ready = (hold == 0);
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_clears_diff", diff, 0);
    chk("borrow_held", borrow_out, prev_borrow);
    if (chk_ser) chk("ser_first_bit", {ser_a, ser_b, ser_d}, 3'b011);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      chk("no_early_valid", out_valid, 0);
      if (chk_ser) chk("ser_in_b1", {ser_a, ser_b, ser_d}, 3'b001);
    end
    @(negedge clk);
    chk("valid_at_t_plus_w", out_valid, 1);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("ser_zero_done", {ser_a, ser_b, ser_d}, 0);
    chk("not_ready_done", in_ready, 0);
    prev_borrow = eb;
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", diff, ed);
      chk("hold_borrow", borrow_out, eb);
      chk("hold_not_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("unload_valid_low", out_valid, 0);
    chk("unload_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    int acc, last_acc, n;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    prev_borrow = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_ser_d", ser_d, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);

    // Directed vectors
    run(8'h5A, 8'h23, 8'h37, 1'b0, 0, 1'b0);
    run(8'h00, 8'h01, 8'hFF, 1'b1, 0, 1'b1);
    run(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    run(8'h80, 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run(8'h9C, 8'h3E, 8'h5E, 1'b0, 20, 1'b0);

    // Reset during shift cycle 4 aborts the word
    a_in     = 8'h37;
    b_in     = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    chk("abort_ready_in_reset", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("abort_ready_after", in_ready, 1);
    prev_borrow = 1'b0;
    run(8'h10, 8'h20, 8'hF0, 1'b1, 0, 1'b0);

    // Back-to-back random words with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    last_acc  = 0;
    for (int i = 0; i < 100; i++) begin
      a    = 8'($urandom_range(0, 255));
      b    = 8'($urandom_range(0, 255));
      a_in = a;
      b_in = b;
      chk("b2b_ready", in_ready, 1);
      acc = cyc;
      if (i > 0) chk("b2b_period", acc - last_acc, 10);
      last_acc = acc;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_latency", n, W);
      chk("b2b_diff", diff, 8'(a - b));
      chk("b2b_borrow", borrow_out, a < b);
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
